// File: rtl/serial_byte_rx_module_pkg.sv
// Shared definitions for the serial byte receiver: FSM state encoding and defaults.
package serial_byte_rx_module_pkg;

  localparam int DATA_W_DEF = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START_CHK = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4
  } rx_state_t;

endpackage

// File: rtl/rx_bit_counter_module.sv
// Data-bit counter: enable + synchronous clear, flags the last data bit (DATA_W-1).
module rx_bit_counter_module #(
  parameter  int DATA_W = 8,
  localparam int CW     = (DATA_W > 1) ? $clog2(DATA_W) : 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tc
);

  logic [CW-1:0] bit_cnt;

  // Count taken data bits; clear wins so the counter wraps to 0 on leaving DATA.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     bit_cnt <= '0;
    else if (clr) bit_cnt <= '0;
    else if (en)  bit_cnt <= bit_cnt + 1'b1;
  end

  assign tc = (bit_cnt == CW'(DATA_W - 1));

endmodule

// File: rtl/serial_byte_rx_module.sv
// Serial-to-parallel deframer: start, DATA_W data bits LSB-first, optional parity, stop.
// Everything advances only on bit_en slots; status pulses last exactly one clk.
module serial_byte_rx_module
  import serial_byte_rx_module_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bit_en,
  input  logic              sin,
  output logic [DATA_W-1:0] byte_out,
  output logic              byte_valid,
  output logic              frame_err,
  output logic              parity_err,
  output logic              busy
);

  rx_state_t         state;
  logic [DATA_W-1:0] shift;
  logic              par_bad;
  logic              last_bit;
  logic              cnt_en;
  logic              cnt_clr;

  // The START_CHK slot already carries data bit 0, so counting starts there.
  assign cnt_en  = bit_en && (state == START_CHK || state == DATA);
  assign cnt_clr = bit_en && (state == DATA) && last_bit;

  rx_bit_counter_module #(.DATA_W(DATA_W)) u_cnt (
    .clk (clk),
    .rst (rst),
    .en  (cnt_en),
    .clr (cnt_clr),
    .tc  (last_bit)
  );

  assign busy = (state != IDLE);

  // Frame FSM, shift register and registered status pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      shift      <= '0;
      par_bad    <= 1'b0;
      byte_out   <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      if (bit_en) begin
        case (state)
          IDLE: begin
            // Clear here so a no-parity build never sees a stale mismatch.
            par_bad <= 1'b0;
            if (!sin) state <= START_CHK;
          end
          START_CHK: begin
            shift <= {sin, shift[DATA_W-1:1]};
            state <= DATA;
          end
          DATA: begin
            shift <= {sin, shift[DATA_W-1:1]};
            if (last_bit) state <= (PARITY_EN != 0) ? PARITY : STOP;
          end
          PARITY: begin
            par_bad <= (^shift) ^ sin ^ 1'(PARITY_ODD);
            state   <= STOP;
          end
          STOP: begin
            // A 0 here is a broken stop bit, never a new start.
            if (sin) begin
              if (par_bad) parity_err <= 1'b1;
              else begin
                byte_out   <= shift;
                byte_valid <= 1'b1;
              end
            end else begin
              frame_err  <= 1'b1;
              parity_err <= par_bad;
            end
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_serial_byte_rx_module.sv
// Bench for serial_byte_rx_module: frames are driven slot by slot, expected
// outcomes are queued at drive time and popped when a status pulse appears.
module tb_serial_byte_rx_module;

  localparam int DATA_W     = 8;
  localparam int PARITY_EN  = 1;
  localparam int PARITY_ODD = 0;

  logic              clk = 1'b0;
  logic              rst;
  logic              bit_en;
  logic              sin;
  logic [DATA_W-1:0] byte_out;
  logic              byte_valid;
  logic              frame_err;
  logic              parity_err;
  logic              busy;

  typedef struct {
    logic              v;
    logic              fe;
    logic              pe;
    logic [DATA_W-1:0] b;
  } exp_t;

  exp_t              q[$];
  logic [DATA_W-1:0] last_good = '0;
  int                total = 0;
  int                bad   = 0;
  int                bsy   = 0;

  serial_byte_rx_module #(
    .DATA_W    (DATA_W),
    .PARITY_EN (PARITY_EN),
    .PARITY_ODD(PARITY_ODD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bit_en    (bit_en),
    .sin       (sin),
    .byte_out  (byte_out),
    .byte_valid(byte_valid),
    .frame_err (frame_err),
    .parity_err(parity_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Any status pulse must match the oldest queued frame outcome.
  always @(negedge clk) begin
    if (byte_valid || frame_err || parity_err) begin
      if (q.size() == 0) chk("unexp_pulse", {byte_valid, frame_err, parity_err}, 0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("byte_valid", byte_valid, e.v);
        chk("frame_err", frame_err, e.fe);
        chk("parity_err", parity_err, e.pe);
        chk("byte_out@pulse", byte_out, e.b);
      end
    end
  end

  // One bit_en slot followed by gap-1 idle clocks; counts busy seen at strobes.
  task automatic slot(input logic b, input int gap);
    sin    = b;
    bit_en = 1'b1;
    if (busy) bsy++;
    @(posedge clk); #1;
    bit_en = 1'b0;
    repeat (gap - 1) begin @(posedge clk); #1; end
  endtask

  task automatic send_frame(input logic [DATA_W-1:0] d, input logic flip,
                            input logic stop, input int gap);
    exp_t e;
    logic pbit;
    // Correct parity bit makes the ones-count match PARITY_ODD; flip corrupts it.
    pbit = (^d) ^ 1'(PARITY_ODD) ^ flip;
    e.v  = stop && !flip;
    e.fe = !stop;
    e.pe = flip && (PARITY_EN != 0);
    if (e.v) last_good = d;
    e.b = last_good;
    q.push_back(e);
    slot(1'b0, gap);
    for (int i = 0; i < DATA_W; i++) slot(d[i], gap);
    if (PARITY_EN != 0) slot(pbit, gap);
    slot(stop, gap);
  endtask

  initial begin
    rst = 1'b0; sin = 1'b1; bit_en = 1'b0;
    // Reset held while inputs wiggle.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      sin    = 1'($urandom);
      bit_en = 1'($urandom);
      @(negedge clk);
      chk("rst_byte_out", byte_out, 0);
      chk("rst_busy", busy, 0);
      chk("rst_pulses", {byte_valid, frame_err, parity_err}, 0);
    end
    @(posedge clk); #1;
    sin = 1'b1; bit_en = 1'b0; rst = 1'b1;
    @(posedge clk); #1;

    send_frame(8'hA5, 1'b0, 1'b1, 1);
    @(negedge clk) chk("good_a5", byte_out, 8'hA5);
    send_frame(8'hA5, 1'b1, 1'b1, 1);
    send_frame(8'h12, 1'b1, 1'b1, 1);
    @(negedge clk) chk("perr_hold", byte_out, 8'hA5);
    send_frame(8'h3C, 1'b0, 1'b0, 1);
    @(negedge clk) chk("ferr_hold", byte_out, 8'hA5);
    send_frame(8'hFF, 1'b0, 1'b1, 1);
    @(negedge clk) chk("good_ff", byte_out, 8'hFF);
    send_frame(8'h66, 1'b1, 1'b0, 1);
    @(negedge clk) chk("fe_pe_hold", byte_out, 8'hFF);

    // Stalled frame: one strobe every 4th clock.
    slot(1'b1, 3);
    bsy = 0;
    send_frame(8'h81, 1'b0, 1'b1, 4);
    @(negedge clk);
    chk("stall_byte", byte_out, 8'h81);
    chk("stall_busy_slots", bsy, 1 + DATA_W + PARITY_EN);
    chk("stall_idle", busy, 0);

    // Back-to-back random frames, no idle slot between them.
    for (int k = 0; k < 4; k++) send_frame(8'($urandom), 1'b0, 1'b1, 1);
    @(negedge clk) chk("b2b_last", byte_out, last_good);

    // Reset in the middle of a frame after data bit 4.
    slot(1'b0, 1);
    for (int i = 0; i < 5; i++) slot(i[0], 1);
    #1 rst = 1'b0;
    #1;
    chk("midrst_byte", byte_out, 0);
    chk("midrst_busy", busy, 0);
    last_good = '0;
    @(posedge clk); #1;
    sin = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    send_frame(8'h5A, 1'b0, 1'b1, 1);
    @(negedge clk) chk("after_rst_5a", byte_out, 8'h5A);

    repeat (4) @(posedge clk);
    chk("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
